// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the program-memory arbiter.
//   state_t : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   grant_t : which requester owns the current access
//   MEM_ADDR_W / MEM_DATA_W : default memory geometry
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_LOADER
  } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker between the CPU and the loader.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   cpu_elig     : CPU request is eligible this cycle
//   ld_elig      : loader request is eligible this cycle
//   update       : commit the current pick into last_grant
//   grant        : combinational winner (meaningful when grant_valid=1)
//   grant_valid  : at least one requester is eligible
// The last_grant register lives here; it resets to LOADER so that the CPU
// wins the first tie after reset.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   cpu_elig,
  input  logic   ld_elig,
  input  logic   update,
  output grant_t grant,
  output logic   grant_valid
);

  grant_t last_grant_reg;

  always_comb begin
    grant       = GRANT_CPU;
    grant_valid = cpu_elig | ld_elig;
    if (cpu_elig && ld_elig) begin
      // Tie: hand the access to whoever did not win last time.
      grant = (last_grant_reg == GRANT_LOADER) ? GRANT_CPU : GRANT_LOADER;
    end else if (ld_elig) begin
      grant = GRANT_LOADER;
    end else begin
      grant = GRANT_CPU;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= GRANT_LOADER;
    end else if (update && grant_valid) begin
      last_grant_reg <= grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported program memory between the CPU
// instruction-fetch port and the program-loader port.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   cpu_req/cpu_addr                : CPU read request, held until cpu_ack
//   cpu_ack/cpu_rdata               : one-cycle completion, read data gated by ack
//   ld_req/ld_we/ld_addr/ld_wdata   : loader request, held until ld_ack
//   ld_lock                         : while high the CPU is never granted
//   ld_ack/ld_rdata                 : one-cycle completion, read data for reads only
//   mem_en/mem_we/mem_addr/mem_wdata: registered memory strobe/controls
//   mem_rdata                       : memory data, valid the cycle after mem_en
// Each access is IDLE (grant) -> ACCESS (mem_en) -> RESP (ack), so a request
// seen in cycle 0 is acknowledged in cycle 2.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state_reg, state_next;
  grant_t grant;
  logic   grant_valid;
  logic   start;

  grant_t            owner_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              we_reg;
  logic              mem_en_reg;
  logic              mem_we_reg;

  // The CPU is masked out entirely while the loader holds the lock.
  rr_arbiter2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .cpu_elig    (cpu_req & ~ld_lock),
    .ld_elig     (ld_req),
    .update      (start),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Requests are only looked at in IDLE; ACCESS and RESP run to completion.
  assign start = (state_reg == IDLE) && grant_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= GRANT_LOADER;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      we_reg     <= 1'b0;
      mem_en_reg <= 1'b0;
      mem_we_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // mem_en/mem_we are high exactly for the ACCESS cycle that follows a grant.
      mem_en_reg <= start;
      mem_we_reg <= start && (grant == GRANT_LOADER) && ld_we;
      if (start) begin
        owner_reg <= grant;
        if (grant == GRANT_LOADER) begin
          addr_reg  <= ld_addr;
          wdata_reg <= ld_wdata;
          we_reg    <= ld_we;
        end else begin
          // CPU fetches are always reads.
          addr_reg  <= cpu_addr;
          wdata_reg <= '0;
          we_reg    <= 1'b0;
        end
      end
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  assign cpu_ack = (state_reg == RESP) && (owner_reg == GRANT_CPU);
  assign ld_ack  = (state_reg == RESP) && (owner_reg == GRANT_LOADER);

  // Read data is passed straight from memory, but only to the acknowledged
  // requester, and never for a loader write.
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign ld_rdata  = (ld_ack && !we_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. The stimulus process
// pushes expected acks and expected memory-port states (tagged with the
// cycle they must appear in); the monitor checks them on the falling edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_lock;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  // Program memory model: mem[5]=1 preloaded, everything else 0.
  logic [DATA_W-1:0] mem [16] = '{5: 1'b1, default: '0};

  typedef struct {
    logic is_ld;
    logic rdata;
    int   cyc;
  } ack_exp_t;

  typedef struct {
    int               cyc;
    logic             full;
    logic             en;
    logic             we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_exp_t;

  ack_exp_t ack_q[$];
  mem_exp_t mem_q[$];
  ack_exp_t a_exp;
  mem_exp_t m_exp;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done = 1'b0;
  int   t0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_lock   (ld_lock),
    .ld_ack    (ld_ack),
    .ld_rdata  (ld_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    // rdata must be 0 whenever its ack is low
    n_cmp++;
    if ((!cpu_ack && cpu_rdata != '0) || (!ld_ack && ld_rdata != '0)) begin
      n_bad++;
      $display("FAIL rdata_gate cyc=%0d got cpu_ack=%0b cpu_rdata=%0b ld_ack=%0b ld_rdata=%0b want rdata 0 without ack",
               cyc, cpu_ack, cpu_rdata, ld_ack, ld_rdata);
    end

    if (cpu_ack || ld_ack) begin
      n_cmp++;
      if (ack_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ack cyc=%0d got cpu_ack=%0b ld_ack=%0b want no ack", cyc, cpu_ack, ld_ack);
      end else begin
        a_exp = ack_q.pop_front();
        if (cpu_ack == a_exp.is_ld || ld_ack != a_exp.is_ld || cyc != a_exp.cyc ||
            (a_exp.is_ld ? ld_rdata : cpu_rdata) != a_exp.rdata) begin
          n_bad++;
          $display("FAIL ack cyc=%0d got cpu_ack=%0b ld_ack=%0b cpu_rdata=%0b ld_rdata=%0b want %s ack rdata=%0b at cyc=%0d",
                   cyc, cpu_ack, ld_ack, cpu_rdata, ld_rdata, a_exp.is_ld ? "LD" : "CPU", a_exp.rdata, a_exp.cyc);
        end else begin
          $display("ack cyc=%0d %s rdata=%0b ok", cyc, a_exp.is_ld ? "LD" : "CPU", a_exp.rdata);
        end
      end
    end

    if (mem_q.size() != 0 && mem_q[0].cyc == cyc) begin
      m_exp = mem_q.pop_front();
      n_cmp++;
      if (mem_en != m_exp.en || mem_we != m_exp.we ||
          (m_exp.full && (mem_addr != m_exp.addr || mem_wdata != m_exp.wdata))) begin
        n_bad++;
        $display("FAIL mem_port cyc=%0d got en=%0b we=%0b addr=%0d wdata=%0b want en=%0b we=%0b addr=%0d wdata=%0b (addr/wdata checked=%0b)",
                 cyc, mem_en, mem_we, mem_addr, mem_wdata, m_exp.en, m_exp.we, m_exp.addr, m_exp.wdata, m_exp.full);
      end else begin
        $display("mem cyc=%0d en=%0b we=%0b addr=%0d ok", cyc, mem_en, mem_we, mem_addr);
      end
    end

    if (done) begin
      n_cmp++;
      if (ack_q.size() != 0) begin
        n_bad++;
        $display("FAIL missing_acks got %0d outstanding want 0", ack_q.size());
      end
      n_cmp++;
      if (mem_q.size() != 0) begin
        n_bad++;
        $display("FAIL missing_mem_checks got %0d outstanding want 0", mem_q.size());
      end
      n_cmp++;
      if (mem[7] != '0) begin
        n_bad++;
        $display("FAIL aborted_write got mem[7]=%0b want 0", mem[7]);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_ack(input logic is_ld, input logic rdata, input int c);
    ack_exp_t e;
    e.is_ld = is_ld;
    e.rdata = rdata;
    e.cyc   = c;
    ack_q.push_back(e);
  endtask

  task automatic exp_mem(input int c, input logic full, input logic en, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    mem_exp_t e;
    e.cyc   = c;
    e.full  = full;
    e.en    = en;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    mem_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_addr = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_lock = 1'b0;

    // Reset values on the memory port
    tick(2);
    exp_mem(cyc, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // CPU read of mem[5]=1
    t0 = cyc;
    cpu_req = 1'b1; cpu_addr = 4'd5;
    exp_mem(t0 + 1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0);
    exp_mem(t0 + 2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    exp_ack(1'b0, 1'b1, t0 + 2);
    tick(3);
    cpu_req = 1'b0;

    // Loader write mem[3]=1
    t0 = cyc;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'd3; ld_wdata = 1'b1;
    exp_mem(t0 + 1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1);
    exp_mem(t0 + 2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    exp_ack(1'b1, 1'b0, t0 + 2);
    tick(3);
    ld_req = 1'b0; ld_we = 1'b0; ld_wdata = 1'b0;

    // CPU reads back mem[3]
    t0 = cyc;
    cpu_req = 1'b1; cpu_addr = 4'd3;
    exp_ack(1'b0, 1'b1, t0 + 2);
    tick(3);
    cpu_req = 1'b0;

    // Loader read of mem[5]
    t0 = cyc;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'd5;
    exp_mem(t0 + 1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0);
    exp_ack(1'b1, 1'b1, t0 + 2);
    tick(3);
    ld_req = 1'b0;

    // Back-to-back CPU: req held through the first ack
    t0 = cyc;
    cpu_req = 1'b1; cpu_addr = 4'd3;
    exp_ack(1'b0, 1'b1, t0 + 2);
    exp_mem(t0 + 4, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
    exp_ack(1'b0, 1'b1, t0 + 5);
    tick(6);
    cpu_req = 1'b0;

    // Fresh reset, then a tie: CPU first, then strict alternation
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    t0 = cyc;
    cpu_req = 1'b1; cpu_addr = 4'd5;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'd2;
    exp_ack(1'b0, 1'b1, t0 + 2);
    exp_ack(1'b1, 1'b0, t0 + 5);
    exp_ack(1'b0, 1'b1, t0 + 8);
    exp_ack(1'b1, 1'b0, t0 + 11);
    tick(12);
    cpu_req = 1'b0; ld_req = 1'b0;
    tick(1);

    // Lock: loader only for 12 cycles, then CPU wins once lock drops
    t0 = cyc;
    ld_lock = 1'b1;
    cpu_req = 1'b1; cpu_addr = 4'd5;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'd3;
    exp_ack(1'b1, 1'b1, t0 + 2);
    exp_ack(1'b1, 1'b1, t0 + 5);
    exp_ack(1'b1, 1'b1, t0 + 8);
    exp_ack(1'b1, 1'b1, t0 + 11);
    tick(12);
    ld_lock = 1'b0;
    exp_ack(1'b0, 1'b1, t0 + 14);
    exp_ack(1'b1, 1'b1, t0 + 17);
    tick(6);
    cpu_req = 1'b0; ld_req = 1'b0;
    tick(1);

    // Reset in the middle of the ACCESS cycle of a write to mem[7]
    t0 = cyc;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'd7; ld_wdata = 1'b1;
    exp_mem(t0 + 1, 1'b1, 1'b1, 1'b1, 4'd7, 1'b1);
    tick(1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    exp_mem(t0 + 2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(1);
    tick(1);
    reset = 1'b0;
    tick(1);

    // After that reset the CPU must again win the first tie
    t0 = cyc;
    cpu_req = 1'b1; cpu_addr = 4'd5;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'd2;
    exp_ack(1'b0, 1'b1, t0 + 2);
    exp_ack(1'b1, 1'b0, t0 + 5);
    tick(6);
    cpu_req = 1'b0; ld_req = 1'b0;
    tick(3);
    done = 1'b1;
  end

endmodule
